// File: rtl/barrel_spawner.sv
// Barrel launcher: paces barrel launches across four slots by round-robin,
// retires finished barrels, and ramps difficulty every eight launches.
module barrel_spawner #(
  parameter logic [15:0] SPAWN_INTERVAL_INIT = 16'd600,
  parameter logic [15:0] SPAWN_INTERVAL_MIN  = 16'd150,
  parameter logic [15:0] SPAWN_STEP          = 16'd50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       over,
  input  logic [3:0] slot_idle,
  input  logic [3:0] slot_done,
  output logic [3:0] launch,
  output logic [3:0] retire,
  output logic [3:0] active,
  output logic [3:0] level,
  output logic [7:0] launched_count
);

  localparam int unsigned N_SLOTS = 4;
  localparam int unsigned PTR_W   = 2;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned LVL_W   = 4;
  localparam int unsigned LC_W    = 8;
  localparam int unsigned MOD_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   interval_q, interval_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [MOD_W-1:0]   mod8_q, mod8_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [LC_W-1:0]    launched_count_q, launched_count_d;
  logic [N_SLOTS-1:0] active_q, active_d;
  logic [N_SLOTS-1:0] launch_q, launch_d;
  logic [N_SLOTS-1:0] retire_q, retire_d;

  logic [N_SLOTS-1:0] eligible;
  logic [N_SLOTS-1:0] done_hit;
  logic               found;
  logic [PTR_W-1:0]   sel;
  logic [PTR_W-1:0]   idx;
  logic [CNT_W:0]     floor_sum;
  logic [CNT_W-1:0]   interval_stepped;

  // Round-robin pick of the first eligible slot starting at rr_ptr
  always_comb begin
    eligible = ~active_q & slot_idle;
    found    = 1'b0;
    sel      = '0;
    idx      = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      idx = rr_ptr_q + PTR_W'(i);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Interval after a level-up, floored without wrapping below the minimum
  always_comb begin
    floor_sum = {1'b0, SPAWN_INTERVAL_MIN} + {1'b0, SPAWN_STEP};
    if ({1'b0, interval_q} >= floor_sum) begin
      interval_stepped = interval_q - SPAWN_STEP;
    end else begin
      interval_stepped = SPAWN_INTERVAL_MIN;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    interval_d       = interval_q;
    rr_ptr_d         = rr_ptr_q;
    mod8_d           = mod8_q;
    level_d          = level_q;
    launched_count_d = launched_count_q;
    active_d         = active_q;
    launch_d         = '0;
    retire_d         = '0;
    done_hit         = slot_done & active_q;

    case (state_q)
      IDLE: begin
        if (start && !over) begin
          state_d          = RUN;
          cnt_d            = '0;
          interval_d       = SPAWN_INTERVAL_INIT;
          level_d          = '0;
          launched_count_d = '0;
          mod8_d           = '0;
        end
      end
      RUN: begin
        if (over) begin
          state_d = FLUSH;
        end else begin
          retire_d = done_hit;
          active_d = active_q & ~done_hit;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (found) begin
            launch_d  = N_SLOTS'(1) << sel;
            active_d  = (active_q & ~done_hit) | (N_SLOTS'(1) << sel);
            cnt_d     = (interval_q == '0) ? '0 : interval_q - CNT_W'(1);
            rr_ptr_d  = sel + PTR_W'(1);
            mod8_d    = mod8_q + MOD_W'(1);
            launched_count_d = (launched_count_q == '1) ? launched_count_q
                                                        : launched_count_q + LC_W'(1);
            // Eighth launch of each group raises difficulty
            if (mod8_q == '1) begin
              level_d    = (level_q == '1) ? level_q : level_q + LVL_W'(1);
              interval_d = interval_stepped;
            end
          end
        end
      end
      FLUSH: begin
        retire_d = active_q;
        active_d = '0;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      interval_q       <= SPAWN_INTERVAL_INIT;
      rr_ptr_q         <= '0;
      mod8_q           <= '0;
      level_q          <= '0;
      launched_count_q <= '0;
      active_q         <= '0;
      launch_q         <= '0;
      retire_q         <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      interval_q       <= interval_d;
      rr_ptr_q         <= rr_ptr_d;
      mod8_q           <= mod8_d;
      level_q          <= level_d;
      launched_count_q <= launched_count_d;
      active_q         <= active_d;
      launch_q         <= launch_d;
      retire_q         <= retire_d;
    end
  end

  assign launch         = launch_q;
  assign retire         = retire_q;
  assign active         = active_q;
  assign level          = level_q;
  assign launched_count = launched_count_q;

endmodule

// File: tb/tb_barrel_spawner.sv
// Scoreboard bench for barrel_spawner: stimulus queues expected pulse events,
// a negedge monitor pops and compares whenever launch or retire is nonzero.
module tb_barrel_spawner;

  typedef struct {
    int         cyc;
    logic [3:0] launch;
    logic [3:0] retire;
    logic [3:0] active;
    logic [3:0] level;
    logic [7:0] count;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       over = 1'b0;
  logic [3:0] slot_idle = 4'h0;
  logic [3:0] slot_done = 4'h0;
  logic [3:0] launch;
  logic [3:0] retire;
  logic [3:0] active;
  logic [3:0] level;
  logic [7:0] launched_count;

  int  cyc = 0;
  int  tests = 0;
  int  fails = 0;
  ev_t exp_q[$];
  ev_t mon_e;

  barrel_spawner #(
    .SPAWN_INTERVAL_INIT(16'd4),
    .SPAWN_INTERVAL_MIN (16'd2),
    .SPAWN_STEP         (16'd1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .over          (over),
    .slot_idle     (slot_idle),
    .slot_done     (slot_done),
    .launch        (launch),
    .retire        (retire),
    .active        (active),
    .level         (level),
    .launched_count(launched_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic push_ev(input int c, input logic [3:0] l, input logic [3:0] r,
                         input logic [3:0] a, input logic [3:0] lv, input logic [7:0] n);
    ev_t e;
    e.cyc = c; e.launch = l; e.retire = r; e.active = a; e.level = lv; e.count = n;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; over = 1'b0; slot_done = 4'h0;
    step(2);
    rst = 1'b1;
  endtask

  // Monitor: every visible pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (rst && (launch != 4'h0 || retire != 4'h0)) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: launch=%b retire=%b at cycle %0d, expected no pulse",
                 launch, retire, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ev_cycle",  cyc,            mon_e.cyc);
        chk("ev_launch", launch,         mon_e.launch);
        chk("ev_retire", retire,         mon_e.retire);
        chk("ev_active", active,         mon_e.active);
        chk("ev_level",  level,          mon_e.level);
        chk("ev_count",  launched_count, mon_e.count);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int c0, c1, e0;
    int t, iv, lv, nc, m, k, nxt, tlast;

    #1 rst = 1'b0;
    #1;
    chk("rst_launch", launch, 4'h0);
    chk("rst_retire", retire, 4'h0);
    chk("rst_active", active, 4'h0);
    chk("rst_level",  level,  4'h0);
    chk("rst_count",  launched_count, 8'h00);
    step(2);
    rst = 1'b1;

    // Four launches spaced by the initial interval, then hold with no free slot
    slot_idle = 4'hF;
    c0 = cyc;
    start = 1'b1;
    push_ev(c0 + 2,  4'b0001, 4'b0000, 4'b0001, 4'd0, 8'd1);
    push_ev(c0 + 6,  4'b0010, 4'b0000, 4'b0011, 4'd0, 8'd2);
    push_ev(c0 + 10, 4'b0100, 4'b0000, 4'b0111, 4'd0, 8'd3);
    push_ev(c0 + 14, 4'b1000, 4'b0000, 4'b1111, 4'd0, 8'd4);
    step(1);
    start = 1'b0;
    step(19);
    e0 = cyc;
    slot_done = 4'b0100;
    slot_idle = 4'b1011;
    push_ev(e0 + 1, 4'b0000, 4'b0100, 4'b1011, 4'd0, 8'd4);
    step(1);
    slot_done = 4'b0000;
    step(2);
    slot_idle = 4'b1111;
    push_ev(e0 + 4, 4'b0100, 4'b0000, 4'b1111, 4'd0, 8'd5);
    drain("drain_rr");
    step(5);

    // Game over with two slots active, start ignored in FLUSH, then restart
    do_reset();
    slot_idle = 4'b0101;
    c0 = cyc;
    start = 1'b1;
    push_ev(c0 + 2, 4'b0001, 4'b0000, 4'b0001, 4'd0, 8'd1);
    push_ev(c0 + 6, 4'b0100, 4'b0000, 4'b0101, 4'd0, 8'd2);
    step(1);
    start = 1'b0;
    step(7);
    over = 1'b1;
    step(1);
    over = 1'b0;
    start = 1'b1;
    push_ev(c0 + 10, 4'b0000, 4'b0101, 4'b0000, 4'd0, 8'd2);
    step(1);
    start = 1'b0;
    step(3);
    chk("flush_active", active, 4'h0);
    c1 = cyc;
    start = 1'b1;
    push_ev(c1 + 2, 4'b0001, 4'b0000, 4'b0001, 4'd0, 8'd1);
    step(1);
    start = 1'b0;
    drain("drain_flush");

    // Asynchronous reset between edges, then start+over together in IDLE
    do_reset();
    slot_idle = 4'hF;
    c0 = cyc;
    start = 1'b1;
    push_ev(c0 + 2, 4'b0001, 4'b0000, 4'b0001, 4'd0, 8'd1);
    step(1);
    start = 1'b0;
    step(2);
    #1 rst = 1'b0;
    #1;
    chk("arst_launch", launch, 4'h0);
    chk("arst_retire", retire, 4'h0);
    chk("arst_active", active, 4'h0);
    chk("arst_level",  level,  4'h0);
    chk("arst_count",  launched_count, 8'h00);
    step(1);
    rst = 1'b1;
    start = 1'b1;
    over = 1'b1;
    step(3);
    start = 1'b0;
    over = 1'b0;
    step(6);
    chk("idle_hold_active", active, 4'h0);
    drain("drain_arst");

    // 300 launches with instant retire: level ramp, interval floor, saturation
    do_reset();
    slot_idle = 4'hF;
    slot_done = 4'hF;
    c0 = cyc;
    t = c0 + 2; iv = 4; lv = 0; nc = 0; m = 0; tlast = t;
    for (int n = 1; n <= 300; n++) begin
      k = (n - 1) % 4;
      nc = (nc < 255) ? nc + 1 : 255;
      m = (m + 1) % 8;
      nxt = iv;
      if (m == 0) begin
        lv = (lv < 15) ? lv + 1 : 15;
        nxt = (iv - 1 < 2) ? 2 : iv - 1;
      end
      push_ev(t,     4'(1 << k), 4'b0000,    4'(1 << k), 4'(lv), 8'(nc));
      push_ev(t + 1, 4'b0000,    4'(1 << k), 4'b0000,    4'(lv), 8'(nc));
      tlast = t;
      t = t + iv;
      iv = nxt;
    end
    start = 1'b1;
    step(1);
    start = 1'b0;
    while (cyc < tlast + 1) step(1);
    over = 1'b1;
    step(1);
    over = 1'b0;
    drain("drain_sat");
    step(2);
    chk("sat_count", launched_count, 8'd255);
    chk("sat_level", level, 4'd15);
    slot_done = 4'h0;
    step(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/barrel_spawner.md
BARREL_SPAWNER -- requirements
Module: barrel_spawner

Interface
REQ-001 SHALL have parameter SPAWN_INTERVAL_INIT, default 16'd600, initial cycles between barrel launches.
REQ-002 SHALL have parameter SPAWN_INTERVAL_MIN, default 16'd150, floor for the launch interval.
REQ-003 SHALL have parameter SPAWN_STEP, default 16'd50, interval decrement per level-up.
REQ-004 SHALL have port clk  input  1  the single clock.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port start  input  1  game start request.
REQ-007 SHALL have port over  input  1  game over, Mario hit.
REQ-008 SHALL have port slot_idle  input  4  per-slot flag: barrel i is in its INITIAL state.
REQ-009 SHALL have port slot_done  input  4  per-slot flag: barrel i reached the bottom land.
REQ-010 SHALL have port launch  output  4  one-cycle pulse; drives start of barrel i.
REQ-011 SHALL have port retire  output  4  one-cycle pulse; drives over of barrel i.
REQ-012 SHALL have port active  output  4  barrel i is in play.
REQ-013 SHALL have port level  output  4  difficulty level, saturating at 15.
REQ-014 SHALL have port launched_count  output  8  total launches, saturating at 255.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and FLUSH, all outputs registered.
REQ-016 SHALL move IDLE->RUN when start=1 and over=0, and load the interval counter cnt=0, interval=SPAWN_INTERVAL_INIT, level=0 and launched_count=0.
REQ-017 SHALL stay in IDLE when start and over are both 1; over has priority.
REQ-018 SHALL treat slot i as eligible when active[i]=0 and slot_idle[i]=1.
REQ-019 SHALL, in RUN with cnt!=0, decrement cnt by 1 each cycle.
REQ-020 SHALL, in RUN with cnt=0 and at least one eligible slot, select slot k by round-robin search starting at rr_ptr (indices rr_ptr..rr_ptr+3 mod 4), then on the next edge set launch[k]=1 for exactly one cycle, active[k]=1, cnt=interval-1, rr_ptr=(k+1) mod 4 and launched_count+1 (saturating).
REQ-021 SHALL, in RUN with cnt=0 and no eligible slot, hold cnt at 0 and launch on the first cycle a slot becomes eligible.
REQ-022 SHALL assert at most one launch bit per cycle.
REQ-023 SHALL, on each launch that makes the pre-saturation launch total a nonzero multiple of 8, set interval=max(interval-SPAWN_STEP, SPAWN_INTERVAL_MIN) with no underflow, and increment level saturating at 15.
REQ-024 SHALL, in RUN when slot_done[i]=1 and active[i]=1, pulse retire[i] for one cycle on the next edge and clear active[i]; slot_done on an inactive slot SHALL be ignored.
REQ-025 SHALL allow a retire and a launch on different slots in the same cycle; a slot retired in cycle t SHALL NOT be launchable before cycle t+1, when slot_idle is resampled.
REQ-026 SHALL move RUN->FLUSH on over=1, suppressing any launch that cycle.
REQ-027 SHALL, in FLUSH, set retire=active and active=0 for one cycle, then move to IDLE; start in FLUSH SHALL be ignored.
REQ-028 SHALL force launch and retire to 0 in every cycle not explicitly pulsing them.

Reset
REQ-029 SHALL, on rst=0 at any time including mid-RUN, immediately set state=IDLE, launch=0, retire=0, active=0, level=0, launched_count=0, cnt=0, rr_ptr=0 and interval=SPAWN_INTERVAL_INIT.
REQ-030 SHALL resume normal operation on the first clk edge after rst returns to 1.

Verification (bench parameters: INIT=4, MIN=2, STEP=1)
REQ-031 SHALL cover: all slot_idle=1, pulse start -> launch=0001 on the first RUN-cycle edge, then 0010, 0100, 1000 spaced 4 cycles apart, with active=1111.
REQ-032 SHALL cover: all four slots active and none done -> no launch and cnt held at 0; slot_done[2]=1 -> retire=0100 and active=1011, then launch=0100 the cycle after slot_idle[2] is seen.
REQ-033 SHALL cover: 8 launches -> level=1 and interval=3; 16 launches -> level=2 and interval=2; 24 launches -> level=3 and interval still 2.
REQ-034 SHALL cover: over=1 in RUN with active=0101 -> retire=0101 for one cycle, active=0000, then IDLE; start during FLUSH is ignored.
REQ-035 SHALL cover: rst=0 asserted asynchronously between edges mid-RUN -> all outputs 0 without waiting for a clk edge; start and over both 1 in IDLE -> stays IDLE.
REQ-036 SHALL cover: 300 launches -> launched_count saturates at 255 and level saturates at 15.
